// File: rtl/mux_pkg.sv
// Shared defaults and the mode encoding for the channel mux/arbiter.
// Pure declarations: no logic, no latency.
package mux_pkg;
  localparam int NCH_DEF   = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;
endpackage

// File: rtl/mux_rr_pick.sv
// Round-robin picker: first valid channel searching upward from ptr_i+1, wrapping.
// Purely combinational; one-hot grant plus its index, all zero when nothing is valid.
module mux_rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         valid_i,
  input  logic [$clog2(NCH)-1:0] ptr_i,
  output logic [NCH-1:0]         gnt_o,
  output logic [$clog2(NCH)-1:0] idx_o
);
  localparam int IW = $clog2(NCH);

  int            cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // i = NCH revisits ptr_i itself, so the last winner is checked last.
    for (int i = 1; i <= NCH; i++) begin
      cand     = (int'(ptr_i) + i) % NCH;
      cand_idx = IW'(cand);
      if (!found && valid_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arb.sv
// NCH:1 mux, fixed-select or round-robin, into one output register; 1-cycle latency, refills in the pop cycle.
// in_ready is zero while the output is held; MUX_RR_ARB_CNT_EN adds saturating per-channel grant counters.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [$clog2(NCH)-1:0] sel,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(NCH)-1:0] out_ch
`ifdef MUX_RR_ARB_CNT_EN
  ,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [15:0]            cnt_value
`endif
);
  localparam int IW = $clog2(NCH);

  logic             run_q;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [IW-1:0]    out_ch_q, out_ch_d;
  logic [IW-1:0]    last_q, last_d;

  logic [NCH-1:0]   rr_gnt, fix_gnt, gnt;
  logic [IW-1:0]    rr_idx, gnt_idx;
  logic             is_rr, free, take;

  mux_rr_pick #(.NCH(NCH)) u_pick (
    .valid_i (in_valid),
    .ptr_i   (last_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx)
  );

  // An out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    fix_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      fix_gnt[k] = in_valid[k] && (sel == IW'(k));
    end
  end

  assign is_rr   = (mode == MODE_RR);
  assign gnt     = is_rr ? rr_gnt : fix_gnt;
  assign gnt_idx = is_rr ? rr_idx : sel;
  assign free    = ~out_vld_q | out_ready;
  // run_q keeps the first edge after reset release from accepting a beat.
  assign in_ready = (run_q && free) ? gnt : '0;
  assign take     = |in_ready;

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_ch_d  = out_ch_q;
    last_d    = last_q;
    if (free) begin
      out_vld_d = take;
      if (take) begin
        out_dat_d = in_data[gnt_idx*WIDTH +: WIDTH];
        out_ch_d  = gnt_idx;
      end
    end
    if (take && is_rr) begin
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_ch_q  <= '0;
      last_q    <= IW'(NCH - 1);
    end else begin
      run_q     <= 1'b1;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_ch_q  <= out_ch_d;
      last_q    <= last_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_RR_ARB_CNT_EN
  logic [15:0] cnt_q [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (take && (cnt_q[gnt_idx] != 16'hFFFF)) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
    end
  end

  assign cnt_value = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : 16'h0000;
`endif
endmodule
